// File: rtl/yin_diff_sweep.sv
// YIN difference-function sweep: for each lag streams a sample window from memory,
// accumulates the squared difference d(tau) and its running sum S(tau), and picks the pitch lag.
`timescale 1ns/1ps
module yin_diff_sweep #(
  parameter int DATA_WIDTH       = 16,
  parameter int WINDOW_SIZE_BITS = 4,
  parameter int ADDR_WIDTH       = 16,
  parameter int TAU_BITS         = 6,
  parameter int MAX_TAU          = 40,
  parameter int THR_FRAC_BITS    = 8,
  localparam int ACC_WIDTH       = 2*DATA_WIDTH + 1 + WINDOW_SIZE_BITS,
  localparam int SUM_WIDTH       = ACC_WIDTH + TAU_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     initial_address,
  input  logic [TAU_BITS-1:0]       max_tau,
  input  logic [THR_FRAC_BITS-1:0]  threshold,
  output logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     data_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [TAU_BITS-1:0]       res_tau,
  output logic [ACC_WIDTH-1:0]      res_d,
  output logic [SUM_WIDTH-1:0]      res_cumsum,
  output logic                      busy,
  output logic                      done,
  output logic                      pitch_found,
  output logic [TAU_BITS-1:0]       pitch_tau
);

  localparam int N  = 1 << WINDOW_SIZE_BITS;
  localparam int CW = WINDOW_SIZE_BITS + 1;
  localparam int PW = SUM_WIDTH + THR_FRAC_BITS;
  localparam logic [TAU_BITS-1:0] MAX_TAU_T = TAU_BITS'(MAX_TAU);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_EMIT, S_FINISH} state_t;

  function automatic logic [TAU_BITS-1:0] clamp_tau(input logic [TAU_BITS-1:0] t);
    if (t == '0) return TAU_BITS'(1);
    if (t > MAX_TAU_T) return MAX_TAU_T;
    return t;
  endfunction

  function automatic logic [2*DATA_WIDTH:0] square(input logic signed [DATA_WIDTH:0] v);
    logic [DATA_WIDTH:0] m;
    m = v[DATA_WIDTH] ? $unsigned(-v) : $unsigned(v);
    return (2*DATA_WIDTH+1)'(m) * (2*DATA_WIDTH+1)'(m);
  endfunction

  // d*tau <= thr*S scaled by 2^Q; a silent window (S=0) only hits on d=0.
  function automatic logic thr_hit(input logic [ACC_WIDTH-1:0] d, input logic [TAU_BITS-1:0] tau,
                                   input logic [SUM_WIDTH-1:0] s, input logic [THR_FRAC_BITS-1:0] thr);
    logic [PW-1:0] lhs, rhs;
    lhs = (PW'(d) * PW'(tau)) << THR_FRAC_BITS;
    rhs = PW'(thr) * PW'(s);
    if (s == '0) return d == '0;
    return lhs <= rhs;
  endfunction

  state_t                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d, cnt_next;
  logic [ADDR_WIDTH-1:0]          base_q, base_d, address_q, address_d;
  logic [THR_FRAC_BITS-1:0]       thr_q, thr_d;
  logic [TAU_BITS-1:0]            tmax_q, tmax_d, tau_q, tau_d;
  logic                           rd_vld_q, rd_vld_d, rd_odd_q, rd_odd_d;
  logic signed [DATA_WIDTH-1:0]   first_q, first_d;
  logic signed [DATA_WIDTH:0]     diff_p0_q, diff_p0_d;
  logic                           vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [2*DATA_WIDTH:0]          sq_p1_q, sq_p1_d;
  logic [ACC_WIDTH-1:0]           acc_q, acc_d;
  logic [SUM_WIDTH-1:0]           sum_q, sum_d, s_now;
  logic                           run_q, run_d, lock_q, lock_d, run_upd, lock_upd, hit;
  logic [TAU_BITS-1:0]            cand_tau_q, cand_tau_d, cand_tau_upd, min_tau_q, min_tau_d, min_tau_upd;
  logic [ACC_WIDTH-1:0]           cand_d_q, cand_d_d, cand_d_upd, min_d_q, min_d_d, min_d_upd;
  logic                           pitch_found_q, pitch_found_d;
  logic [TAU_BITS-1:0]            pitch_tau_q, pitch_tau_d;

  assign s_now = sum_q + SUM_WIDTH'(acc_q);
  assign hit   = thr_hit(acc_q, tau_q, s_now, thr_q);

  // Pitch tracking for the lag currently on the result port.
  always_comb begin
    run_upd      = run_q;
    lock_upd     = lock_q;
    cand_tau_upd = cand_tau_q;
    cand_d_upd   = cand_d_q;
    min_tau_upd  = min_tau_q;
    min_d_upd    = min_d_q;
    if (tau_q == TAU_BITS'(1) || acc_q < min_d_q) begin
      min_tau_upd = tau_q;
      min_d_upd   = acc_q;
    end
    if (!lock_q) begin
      if (run_q) begin
        if (acc_q < cand_d_q) begin
          cand_tau_upd = tau_q;
          cand_d_upd   = acc_q;
        end else begin
          lock_upd = 1'b1;
        end
      end else if (hit) begin
        run_upd      = 1'b1;
        cand_tau_upd = tau_q;
        cand_d_upd   = acc_q;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cnt_next      = cnt_q + CW'(1);
    base_d        = base_q;
    address_d     = address_q;
    thr_d         = thr_q;
    tmax_d        = tmax_q;
    tau_d         = tau_q;
    sum_d         = sum_q;
    run_d         = run_q;
    lock_d        = lock_q;
    cand_tau_d    = cand_tau_q;
    cand_d_d      = cand_d_q;
    min_tau_d     = min_tau_q;
    min_d_d       = min_d_q;
    pitch_found_d = pitch_found_q;
    pitch_tau_d   = pitch_tau_q;

    // Read return: even beats hold x[base+j], odd beats form the difference.
    rd_vld_d  = (state_q == S_READ);
    rd_odd_d  = cnt_q[0];
    first_d   = first_q;
    diff_p0_d = diff_p0_q;
    if (rd_vld_q && !rd_odd_q) first_d = $signed(data_out);
    vld_p0_d = rd_vld_q && rd_odd_q;
    if (vld_p0_d)
      diff_p0_d = $signed({first_q[DATA_WIDTH-1], first_q}) - $signed({data_out[DATA_WIDTH-1], data_out});
    // Square, then accumulate.
    vld_p1_d = vld_p0_q;
    sq_p1_d  = vld_p0_q ? square(diff_p0_q) : sq_p1_q;
    acc_d    = vld_p1_q ? acc_q + ACC_WIDTH'(sq_p1_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = initial_address;
          address_d   = initial_address;
          thr_d       = threshold;
          tmax_d      = clamp_tau(max_tau);
          tau_d       = TAU_BITS'(1);
          cnt_d       = '0;
          acc_d       = '0;
          sum_d       = '0;
          run_d       = 1'b0;
          lock_d      = 1'b0;
          cand_tau_d  = '0;
          cand_d_d    = '0;
          min_tau_d   = '0;
          min_d_d     = '0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == CW'(2*N-1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d     = cnt_next;
          address_d = base_q + ADDR_WIDTH'(cnt_next[CW-1:1]) + (cnt_next[0] ? ADDR_WIDTH'(tau_q) : '0);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(2)) state_d = S_EMIT;
        else cnt_d = cnt_next;
      end
      S_EMIT: begin
        if (res_ready) begin
          sum_d      = s_now;
          run_d      = run_upd;
          lock_d     = lock_upd;
          cand_tau_d = cand_tau_upd;
          cand_d_d   = cand_d_upd;
          min_tau_d  = min_tau_upd;
          min_d_d    = min_d_upd;
          if (tau_q == tmax_q) begin
            pitch_found_d = run_upd;
            pitch_tau_d   = run_upd ? cand_tau_upd : min_tau_upd;
            state_d       = S_FINISH;
          end else begin
            tau_d     = tau_q + TAU_BITS'(1);
            cnt_d     = '0;
            acc_d     = '0;
            address_d = base_q;
            state_d   = S_READ;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      base_q        <= '0;
      address_q     <= '0;
      thr_q         <= '0;
      tmax_q        <= '0;
      tau_q         <= '0;
      rd_vld_q      <= 1'b0;
      rd_odd_q      <= 1'b0;
      first_q       <= '0;
      diff_p0_q     <= '0;
      vld_p0_q      <= 1'b0;
      sq_p1_q       <= '0;
      vld_p1_q      <= 1'b0;
      acc_q         <= '0;
      sum_q         <= '0;
      run_q         <= 1'b0;
      lock_q        <= 1'b0;
      cand_tau_q    <= '0;
      cand_d_q      <= '0;
      min_tau_q     <= '0;
      min_d_q       <= '0;
      pitch_found_q <= 1'b0;
      pitch_tau_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      address_q     <= address_d;
      thr_q         <= thr_d;
      tmax_q        <= tmax_d;
      tau_q         <= tau_d;
      rd_vld_q      <= rd_vld_d;
      rd_odd_q      <= rd_odd_d;
      first_q       <= first_d;
      diff_p0_q     <= diff_p0_d;
      vld_p0_q      <= vld_p0_d;
      sq_p1_q       <= sq_p1_d;
      vld_p1_q      <= vld_p1_d;
      acc_q         <= acc_d;
      sum_q         <= sum_d;
      run_q         <= run_d;
      lock_q        <= lock_d;
      cand_tau_q    <= cand_tau_d;
      cand_d_q      <= cand_d_d;
      min_tau_q     <= min_tau_d;
      min_d_q       <= min_d_d;
      pitch_found_q <= pitch_found_d;
      pitch_tau_q   <= pitch_tau_d;
    end
  end

  assign address     = address_q;
  assign res_valid   = (state_q == S_EMIT);
  assign res_tau     = tau_q;
  assign res_d       = acc_q;
  assign res_cumsum  = s_now;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign pitch_found = pitch_found_q;
  assign pitch_tau   = pitch_tau_q;

endmodule

// File: doc/yin_diff_sweep.md
YIN_DIFF_SWEEP -- requirements
Module: yin_diff_sweep

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample width, two's complement.
REQ-002 SHALL have parameter WINDOW_SIZE_BITS, default 4: window N = 2^WINDOW_SIZE_BITS samples.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16: sample memory address width.
REQ-004 SHALL have parameter TAU_BITS, default 6, and MAX_TAU, default 40: lag field width and upper lag bound.
REQ-005 SHALL have parameter THR_FRAC_BITS, default 8: fractional bits Q of the threshold.
REQ-006 SHALL derive ACC_WIDTH = 2*DATA_WIDTH+1+WINDOW_SIZE_BITS and SUM_WIDTH = ACC_WIDTH+TAU_BITS.
REQ-007 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  synchronous, active-high.
REQ-008 SHALL have ports: start  in  1  sweep request; initial_address  in  ADDR_WIDTH  window base; max_tau  in  TAU_BITS  last lag; threshold  in  THR_FRAC_BITS  absolute threshold, Q0.THR_FRAC_BITS.
REQ-009 SHALL have ports: address  out  ADDR_WIDTH  memory read address; data_out  in  DATA_WIDTH  memory word, valid one cycle after address.
REQ-010 SHALL have ports: res_valid  out  1; res_ready  in  1; res_tau  out  TAU_BITS; res_d  out  ACC_WIDTH  d(tau); res_cumsum  out  SUM_WIDTH  S(tau).
REQ-011 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; pitch_found  out  1; pitch_tau  out  TAU_BITS.

Function
REQ-012 SHALL compute, for tau = 1..T, d(tau) = sum over j=0..N-1 of (x[base+j] - x[base+j+tau])^2, and S(tau) = d(1)+...+d(tau).
REQ-013 SHALL sample initial_address, threshold and T on the start cycle; T = max_tau clamped to range 1..MAX_TAU.
REQ-014 SHALL ignore start while busy=1.
REQ-015 SHALL use states IDLE -> READ -> DRAIN -> EMIT -> (READ for next tau | FINISH) -> IDLE.
REQ-016 In READ SHALL drive 2N consecutive addresses, alternating base+j and base+j+tau for j = 0..N-1, one per cycle.
REQ-017 SHALL compute address modulo 2^ADDR_WIDTH; wrap past all-ones is legal.
REQ-018 SHALL pipeline difference (DATA_WIDTH+1 bits), square and accumulate, with no overflow at any width.
REQ-019 SHALL assert res_valid exactly 2N+3 cycles after entering READ for that tau, and clear the accumulator at READ entry.
REQ-020 SHALL hold res_valid, res_tau, res_d, res_cumsum and address stable, and issue no new reads, while res_valid=1 and res_ready=0.
REQ-021 SHALL complete the handshake on a cycle with res_valid=1 and res_ready=1, and enter READ for tau+1 on the next cycle; if tau=T, enter FINISH instead.
REQ-022 SHALL evaluate the threshold division-free: a hit at tau is d(tau)*tau*2^THR_FRAC_BITS <= threshold*S(tau); when S(tau)=0, a hit is d(tau)=0.
REQ-023 After the first hit, SHALL continue while d(tau+1) < d(tau), and SHALL set pitch_tau to the last tau of that decreasing run, with pitch_found=1.
REQ-024 With no hit, SHALL set pitch_found=0 and pitch_tau to the smallest tau with minimal d(tau).
REQ-025 SHALL still emit every tau up to T once a pitch is fixed.
REQ-026 In FINISH SHALL pulse done for one cycle, valid together with the updated pitch_found and pitch_tau, then return to IDLE.
REQ-027 SHALL hold pitch_found and pitch_tau until the next start.
REQ-028 SHALL keep busy=1 from the cycle after start through the done cycle.

Reset
REQ-029 While reset=1, SHALL enter IDLE on the next edge, independent of state.
REQ-030 While reset=1, SHALL zero address, res_valid, res_tau, res_d, res_cumsum, busy, done, pitch_found, pitch_tau and all accumulators.
REQ-031 On reset mid-sweep, SHALL discard partial results and SHALL NOT pulse done.
REQ-032 SHALL accept start on the first cycle after reset deasserts.

Verification
REQ-033 Ramp: memory[i]=i+1, N=16, max_tau=4, threshold=26, res_ready=1 -> res_d 16,64,144,256; res_cumsum 16,80,224,480; first res_valid 35 cycles after READ entry; done with pitch_found=0, pitch_tau=1.
REQ-034 Periodic: memory[i]=100*(i mod 8), max_tau=12, threshold=26 -> res_d(8)=0; done with pitch_found=1, pitch_tau=8; all 12 results emitted.
REQ-035 Backpressure: ramp, res_ready=0 for 20 cycles after first res_valid -> outputs and address frozen, tau=2 READ begins the cycle after res_ready rises.
REQ-036 Reset mid-sweep at tau=2 and start asserted while busy -> start ignored; after reset all outputs 0, no done; fresh start reproduces the REQ-033 results.
REQ-037 Bounds: max_tau=0 -> exactly one result (tau=1); max_tau=63 -> 40 results.
REQ-038 Wrap: initial_address=16'hFFF8 -> addresses wrap to 0.
